// File: rtl/timer_unit.sv
// Programmable timer: TIMA counts falling edges of a divider tap gated by TAC,
// and after an overflow holds 0x00 for a while before reloading from TMA and raising irq.
module timer_unit #(
  parameter int OVF_DELAY = 4  // visible 0x00 cycles after overflow, must be >= 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] div,
  input  logic [1:0]  addr,
  input  logic        sel,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        irq,
  input  logic        irq_ack
);

  // state  | meaning
  // RUN    | TIMA counts falling tick edges
  // OVF    | TIMA wrapped to 0x00, waiting; a TIMA write aborts the reload
  // RELOAD | single cycle: TIMA <= TMA, irq set
  typedef enum logic [1:0] {RUN, OVF, RELOAD} state_t;

  localparam int CNT_W = (OVF_DELAY > 2) ? $clog2(OVF_DELAY) : 1;
  // RELOAD itself is one of the 0x00 cycles, so OVF lasts OVF_DELAY-1 cycles
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVF_DELAY - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tima_q, tima_d;
  logic [7:0]       tma_q;
  logic [2:0]       tac_q;
  logic             irq_q, irq_d;
  logic             tick_q;
  logic             tap, tick, fall;
  logic             wr, wr_tima, wr_tma, wr_tac;
  logic             div_unused;

  assign div_unused = ^{div[15:10], div[8], div[6], div[4], div[2:0]};

  assign wr      = sel & cpu_wr;
  assign wr_tima = wr & (addr == 2'd1);
  assign wr_tma  = wr & (addr == 2'd2);
  assign wr_tac  = wr & (addr == 2'd3);

  always_comb begin
    case (tac_q[1:0])
      2'd0:    tap = div[9];
      2'd1:    tap = div[3];
      2'd2:    tap = div[5];
      default: tap = div[7];
    endcase
  end

  assign tick = tap & tac_q[2];
  assign fall = tick_q & ~tick;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
      irq_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tima_q  <= tima_d;
      irq_q   <= irq_d;
      tick_q  <= tick;
      if (wr_tma) tma_q <= d_in;
      if (wr_tac) tac_q <= d_in[2:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tima_d  = tima_q;
    irq_d   = irq_ack ? 1'b0 : irq_q;
    case (state_q)
      RUN: begin
        if (wr_tima) begin
          tima_d = d_in;
        end else if (fall) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = OVF;
            cnt_d   = '0;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      OVF: begin
        if (wr_tima) begin
          tima_d  = d_in;
          state_d = RUN;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELOAD: begin
        // a TMA write in this cycle goes straight through to TIMA
        tima_d  = wr_tma ? d_in : tma_q;
        irq_d   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    case (addr)
      2'd1:    d_out = tima_q;
      2'd2:    d_out = tma_q;
      2'd3:    d_out = {5'b11111, tac_q};
      default: d_out = 8'hFF;
    endcase
  end

  assign d_oe = sel & cpu_rd & (addr != 2'd0);
  assign irq  = irq_q;

endmodule

// File: tb/tb_timer_unit.sv
// Bench for timer_unit: directed scenarios with fixed expectations, then random
// traffic against a cycle-level model built from the register rules.
module tb_timer_unit;

  localparam int OVF_DELAY = 4;

  logic        clk = 1'b0;
  logic        nreset;
  logic [15:0] div;
  logic [1:0]  addr;
  logic        sel, cpu_rd, cpu_wr;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe, irq, irq_ack;

  int checks = 0;
  int errors = 0;

  timer_unit #(.OVF_DELAY(OVF_DELAY)) dut (
    .clk(clk), .nreset(nreset), .div(div), .addr(addr), .sel(sel),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .d_in(d_in), .d_out(d_out),
    .d_oe(d_oe), .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // reference model: m_since counts cycles since the wrap, 0 when idle
  logic [7:0] m_tima, m_tma;
  logic [2:0] m_tac;
  logic       m_irq, m_prev;
  int         m_since;
  logic       m_wr;
  assign m_wr = sel && cpu_wr;

  function automatic logic f_tick(input logic [2:0] t, input logic [15:0] d);
    case (t[1:0])
      2'd0:    return t[2] & d[9];
      2'd1:    return t[2] & d[3];
      2'd2:    return t[2] & d[5];
      default: return t[2] & d[7];
    endcase
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_tima <= 8'h00; m_tma <= 8'h00; m_tac <= 3'b000;
      m_irq <= 1'b0; m_prev <= 1'b0; m_since <= 0;
    end else begin
      if (m_since == OVF_DELAY) begin
        m_tima  <= (m_wr && addr == 2'd2) ? d_in : m_tma;
        m_since <= 0;
      end else if (m_since > 0) begin
        if (m_wr && addr == 2'd1) begin
          m_tima  <= d_in;
          m_since <= 0;
        end else begin
          m_since <= m_since + 1;
        end
      end else if (m_wr && addr == 2'd1) begin
        m_tima <= d_in;
      end else if (m_prev && !f_tick(m_tac, div)) begin
        if (m_tima == 8'hFF) begin
          m_tima  <= 8'h00;
          m_since <= 1;
        end else begin
          m_tima <= m_tima + 8'd1;
        end
      end
      m_irq  <= (m_since == OVF_DELAY) ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
      if (m_wr && addr == 2'd2) m_tma <= d_in;
      if (m_wr && addr == 2'd3) m_tac <= d_in[2:0];
      m_prev <= f_tick(m_tac, div);
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); sel = 1'b1; cpu_wr = 1'b1; addr = a; d_in = d;
    @(negedge clk); sel = 1'b0; cpu_wr = 1'b0; addr = 2'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v, output logic oe);
    sel = 1'b1; cpu_rd = 1'b1; addr = a;
    #1;
    v = d_out; oe = d_oe;
    sel = 1'b0; cpu_rd = 1'b0; addr = 2'd0;
  endtask

  task automatic ack_irq();
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
  endtask

  // with TAC=0x05 and div=16: a div[3] high cycle then a fall; returns on the
  // negedge where the falling value is applied
  task automatic arm_overflow();
    @(negedge clk); div = 16'd8;
    @(negedge clk); div = 16'd16;
  endtask

  task automatic test_reset();
    logic [7:0] v; logic oe;
    nreset = 1'b0; div = 16'h0200; addr = 2'd0; sel = 1'b0; cpu_rd = 1'b0;
    cpu_wr = 1'b0; d_in = 8'h00; irq_ack = 1'b0;
    repeat (2) @(negedge clk);
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_tima: got %h expected %h", v, 8'h00); end
    rd(2'd2, v, oe); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_tma: got %h expected %h", v, 8'h00); end
    rd(2'd3, v, oe); checks++;
    if (v !== 8'hF8) begin errors++; $display("FAIL reset_tac: got %h expected %h", v, 8'hF8); end
    checks++;
    if (oe !== 1'b1) begin errors++; $display("FAIL reset_oe3: got %b expected 1", oe); end
    rd(2'd0, v, oe); checks++;
    if (v !== 8'hFF || oe !== 1'b0) begin errors++; $display("FAIL addr0_read: got %h/%b expected ff/0", v, oe); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    @(negedge clk); nreset = 1'b1;
    repeat (3) @(negedge clk);
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL release_no_inc: got %h expected %h", v, 8'h00); end
    div = 16'h0000;
  endtask

  task automatic test_count();
    logic [7:0] v; logic oe;
    wr(2'd1, 8'h00);
    wr(2'd3, 8'h05);
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk); div = 16'(i);
      if (i == 40) begin
        rd(2'd1, v, oe); checks++;
        if (v !== 8'h02) begin errors++; $display("FAIL count_mid: got %h expected %h", v, 8'h02); end
      end
    end
    @(negedge clk);
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL count_tima: got %h expected %h", v, 8'h04); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL count_irq: got %b expected 0", irq); end
  endtask

  task automatic test_overflow();
    logic [7:0] v; logic oe;
    wr(2'd3, 8'h00); wr(2'd2, 8'hAB); wr(2'd1, 8'hFF); wr(2'd3, 8'h05);
    div = 16'd16;
    arm_overflow();
    for (int k = 1; k <= OVF_DELAY; k++) begin
      @(negedge clk);
      rd(2'd1, v, oe); checks++;
      if (v !== 8'h00 || irq !== 1'b0) begin
        errors++; $display("FAIL ovf_hold%0d: got %h irq %b expected 00 irq 0", k, v, irq);
      end
    end
    @(negedge clk);
    rd(2'd1, v, oe); checks++;
    if (v !== 8'hAB || irq !== 1'b1) begin
      errors++; $display("FAIL ovf_reload: got %h irq %b expected ab irq 1", v, irq);
    end
  endtask

  task automatic test_irq_ack();
    logic [7:0] v; logic oe;
    ack_irq(); checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b expected 0", irq); end
    wr(2'd1, 8'hFF);
    arm_overflow();
    repeat (OVF_DELAY - 1) @(negedge clk);
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    rd(2'd1, v, oe); checks++;
    if (irq !== 1'b1 || v !== 8'hAB) begin
      errors++; $display("FAIL ack_vs_reload: got irq %b tima %h expected irq 1 tima ab", irq, v);
    end
    @(negedge clk); checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_level: got %b expected 1", irq); end
  endtask

  task automatic test_ovf_abort();
    logic [7:0] v; logic oe;
    ack_irq();
    wr(2'd1, 8'hFF);
    arm_overflow();
    @(negedge clk);
    @(negedge clk); sel = 1'b1; cpu_wr = 1'b1; addr = 2'd1; d_in = 8'h42;
    @(negedge clk); sel = 1'b0; cpu_wr = 1'b0; addr = 2'd0;
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h42 || irq !== 1'b0) begin
      errors++; $display("FAIL abort_write: got %h irq %b expected 42 irq 0", v, irq);
    end
    repeat (6) @(negedge clk);
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h42 || irq !== 1'b0) begin
      errors++; $display("FAIL abort_no_reload: got %h irq %b expected 42 irq 0", v, irq);
    end
  endtask

  task automatic test_reload_writes();
    logic [7:0] v; logic oe;
    wr(2'd2, 8'h10); wr(2'd1, 8'hFF);
    arm_overflow();
    repeat (OVF_DELAY - 1) @(negedge clk);
    @(negedge clk); sel = 1'b1; cpu_wr = 1'b1; addr = 2'd2; d_in = 8'h77;
    @(negedge clk); sel = 1'b0; cpu_wr = 1'b0; addr = 2'd0;
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h77) begin errors++; $display("FAIL reload_tma_wr_tima: got %h expected %h", v, 8'h77); end
    rd(2'd2, v, oe); checks++;
    if (v !== 8'h77) begin errors++; $display("FAIL reload_tma_wr_tma: got %h expected %h", v, 8'h77); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL reload_tma_irq: got %b expected 1", irq); end
    ack_irq();
    wr(2'd1, 8'hFF);
    arm_overflow();
    repeat (OVF_DELAY - 1) @(negedge clk);
    @(negedge clk); sel = 1'b1; cpu_wr = 1'b1; addr = 2'd1; d_in = 8'h55;
    @(negedge clk); sel = 1'b0; cpu_wr = 1'b0; addr = 2'd0;
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h77 || irq !== 1'b1) begin
      errors++; $display("FAIL reload_tima_wr: got %h irq %b expected 77 irq 1", v, irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v; logic oe;
    ack_irq();
    wr(2'd1, 8'h10);
    @(negedge clk); div = 16'd8;
    @(negedge clk); div = 16'd16; sel = 1'b1; cpu_wr = 1'b1; addr = 2'd1; d_in = 8'h20;
    @(negedge clk); sel = 1'b0; cpu_wr = 1'b0; addr = 2'd0;
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h20) begin errors++; $display("FAIL wr_beats_tick: got %h expected %h", v, 8'h20); end
    arm_overflow();
    @(negedge clk);
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h21) begin errors++; $display("FAIL next_tick: got %h expected %h", v, 8'h21); end
  endtask

  task automatic test_tac_write();
    logic [7:0] v; logic oe;
    wr(2'd3, 8'h00); wr(2'd1, 8'h30);
    div = 16'h0200;
    wr(2'd3, 8'h04);
    wr(2'd3, 8'h00);
    @(negedge clk);
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h31) begin errors++; $display("FAIL tac_write_edge: got %h expected %h", v, 8'h31); end
    div = 16'h0000;
    repeat (4) @(negedge clk);
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h31) begin errors++; $display("FAIL tac_write_hold: got %h expected %h", v, 8'h31); end
    div = 16'h0200;
    wr(2'd3, 8'h04);
    @(negedge clk); div = 16'h0000;
    @(negedge clk);
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h32) begin errors++; $display("FAIL div_clear_edge: got %h expected %h", v, 8'h32); end
    repeat (3) @(negedge clk);
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h32) begin errors++; $display("FAIL div_clear_hold: got %h expected %h", v, 8'h32); end
  endtask

  task automatic test_reset_ovf();
    logic [7:0] v; logic oe;
    wr(2'd3, 8'h05); wr(2'd2, 8'hAB); wr(2'd1, 8'hFF);
    div = 16'd16;
    arm_overflow();
    @(negedge clk);
    @(negedge clk); nreset = 1'b0;
    #2 nreset = 1'b1;
    rd(2'd1, v, oe); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rst_ovf_tima: got %h expected %h", v, 8'h00); end
    rd(2'd2, v, oe); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rst_ovf_tma: got %h expected %h", v, 8'h00); end
    rd(2'd3, v, oe); checks++;
    if (v !== 8'hF8) begin errors++; $display("FAIL rst_ovf_tac: got %h expected %h", v, 8'hF8); end
    repeat (6) @(negedge clk);
    rd(2'd1, v, oe); checks++;
    if (irq !== 1'b0 || v !== 8'h00) begin
      errors++; $display("FAIL rst_ovf_no_irq: got irq %b tima %h expected irq 0 tima 00", irq, v);
    end
  endtask

  task automatic test_random();
    logic [7:0] v, exp; logic oe;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      sel = 1'b0; cpu_wr = 1'b0; irq_ack = 1'b0;
      for (int a = 1; a <= 3; a++) begin
        rd(2'(a), v, oe);
        case (a)
          1:       exp = m_tima;
          2:       exp = m_tma;
          default: exp = {5'b11111, m_tac};
        endcase
        checks++;
        if (v !== exp || oe !== 1'b1) begin
          errors++; $display("FAIL rand_read a=%0d cyc=%0d: got %h oe %b expected %h oe 1", a, n, v, oe, exp);
        end
      end
      checks++;
      if (irq !== m_irq) begin errors++; $display("FAIL rand_irq cyc=%0d: got %b expected %b", n, irq, m_irq); end
      case ($urandom_range(0, 99))
        0, 1:    div = 16'h0000;
        2, 3:    div = 16'($urandom);
        default: div = div + 16'd1;
      endcase
      case ($urandom_range(0, 15))
        0, 1: begin
          sel = 1'b1; cpu_wr = 1'b1; addr = 2'($urandom_range(0, 3));
          d_in = (addr == 2'd1 && $urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255)) : 8'($urandom);
        end
        2: begin
          cpu_wr = 1'b1; addr = 2'($urandom_range(0, 3)); d_in = 8'($urandom);
        end
        default: ;
      endcase
      irq_ack = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    sel = 1'b0; cpu_wr = 1'b0; irq_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_count();
    test_overflow();
    test_irq_ack();
    test_ovf_abort();
    test_reload_writes();
    test_back_to_back();
    test_tac_write();
    test_reset_ovf();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
